// File: rtl/ucore_input_fifo.sv
// ucore_input_fifo: per-channel NoC token buffer feeding the ucore firing logic.
// Define UCORE_INPUT_FIFO_CONST_EN to add a constant-operand override.
module ucore_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  noc_ivalid,
   input  logic [DATA_WIDTH-1:0] noc_in,
   output logic                  noc_oready,
   input  logic                  flush,
`ifdef UCORE_INPUT_FIFO_CONST_EN
   input  logic                  cfg_const_en,
   input  logic [DATA_WIDTH-1:0] cfg_const_val,
`endif
   output logic                  ucore_valid,
   output logic [DATA_WIDTH-1:0] ucore_data,
   input  logic                  ucore_pop,
   output logic [CNT_W-1:0]      occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  const_en, fifo_valid, full, push, pop;
   logic [DATA_WIDTH-1:0] const_val;
`ifdef UCORE_INPUT_FIFO_CONST_EN
   assign const_en  = cfg_const_en;
   assign const_val = cfg_const_val;
`else
   assign const_en  = 1'b0;
   assign const_val = '0;
`endif
   assign fifo_valid  = cnt_q != '0;
   assign full        = cnt_q == CNT_W'(DEPTH);
   // ready depends only on registered count, so a same-cycle pop never opens a full buffer
   assign noc_oready  = ~full & ~const_en;
   assign push        = noc_ivalid & noc_oready;
   assign pop         = ucore_pop & fifo_valid & ~const_en;
   assign ucore_valid = const_en | fifo_valid;
   assign ucore_data  = const_en ? const_val : fifo_valid ? mem_q[rd_q] : '0;
   assign occupancy   = cnt_q;
   always_comb begin
      wr_d  = flush ? '0 : wr_q + PTR_W'(push);
      rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
      cnt_d = flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= noc_in;
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(full && push) && cnt_q <= CNT_W'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(cnt_q == '0 && pop));
endmodule

// File: tb/tb_ucore_input_fifo.sv
// tb_ucore_input_fifo: directed and random checks against a queue-based token model.
module tb_ucore_input_fifo;
   localparam int DW = 32;
   localparam int DEPTH = 2;
   localparam int CW = $clog2(DEPTH + 1);
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          noc_ivalid = 1'b0;
   logic [DW-1:0] noc_in = '0;
   logic          noc_oready;
   logic          flush = 1'b0;
   logic          ucore_valid;
   logic [DW-1:0] ucore_data;
   logic          ucore_pop = 1'b0;
   logic [CW-1:0] occupancy;
   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] q[$];

   ucore_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .noc_ivalid(noc_ivalid), .noc_in(noc_in),
      .noc_oready(noc_oready), .flush(flush), .ucore_valid(ucore_valid),
      .ucore_data(ucore_data), .ucore_pop(ucore_pop), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      int n = q.size();
      chk({tag, ".oready"}, 32'(noc_oready), 32'(n != DEPTH));
      chk({tag, ".valid"}, 32'(ucore_valid), 32'(n != 0));
      chk({tag, ".data"}, ucore_data, n != 0 ? q[0] : 32'h0);
      chk({tag, ".occ"}, 32'(occupancy), 32'(n));
   endtask

   // outputs are checked before the edge, then the queue model advances by one cycle
   task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic p, input logic f);
      bit acc, dq;
      noc_ivalid = v;
      noc_in = d;
      ucore_pop = p;
      flush = f;
      chk_all(tag);
      acc = v && q.size() < DEPTH;
      dq = p && q.size() > 0;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (dq) void'(q.pop_front());
         if (acc) q.push_back(d);
      end
      #1;
   endtask

   initial begin
      #2;
      chk_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("idle_pop", 1'b0, '0, 1'b1, 1'b0);
      step("push_a5", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
      chk("latency.data", ucore_data, 32'hA5A5_0001);
      step("flush0", 1'b0, '0, 1'b0, 1'b1);
      step("fill11", 1'b1, 32'h11, 1'b0, 1'b0);
      step("fill22", 1'b1, 32'h22, 1'b0, 1'b0);
      chk("full.oready", 32'(noc_oready), 32'h0);
      step("hold33", 1'b1, 32'h33, 1'b1, 1'b0);
      chk("no_passthru.head", ucore_data, 32'h22);
      chk("no_passthru.occ", 32'(occupancy), 32'd1);
      step("take33", 1'b1, 32'h33, 1'b0, 1'b0);
      chk("take33.occ", 32'(occupancy), 32'd2);
      step("flush1", 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step("stream", 1'b1, 32'(i), 1'b1, 1'b0);
         chk("stream.head", ucore_data, 32'(i));
      end
      step("drain", 1'b0, '0, 1'b1, 1'b0);
      step("f11", 1'b1, 32'h11, 1'b0, 1'b0);
      step("f22", 1'b1, 32'h22, 1'b0, 1'b0);
      step("flush_full", 1'b1, 32'h44, 1'b1, 1'b1);
      chk("flush.valid", 32'(ucore_valid), 32'h0);
      chk_all("post_flush");
      step("r1", 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
      step("r2", 1'b1, 32'hCAFE_0002, 1'b0, 1'b0);
      chk("pre_rst.occ", 32'(occupancy), 32'd2);
      noc_ivalid = 1'b0;
      ucore_pop = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk_all("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_rst_idle", 1'b0, '0, 1'b1, 1'b0);
      step("post_rst_push", 1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
      chk("post_rst.head", ucore_data, 32'hBEEF_0001);
      step("post_rst_pp", 1'b1, 32'hBEEF_0002, 1'b1, 1'b0);
      chk("post_rst.pp", ucore_data, 32'hBEEF_0002);
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      chk_all("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
